// File: rtl/conv_stream_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream_feeder_if
// Brief    : Operand word stream from the feeder to the MAC controller.
// Revision : 1.0
// ============================================================================
interface conv_stream_feeder_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_is_weight;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_is_weight,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_is_weight,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/conv_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream_feeder
// Brief    : Walks the conv loop nest, reads operands, streams them out.
// Revision : 1.0
// ============================================================================
module conv_stream_feeder #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int WEIGHT_BASE        = 0,
    parameter int ACT_BASE           = 2**19
) (
    input  wire logic                          clk,
    input  wire logic                          rst_in,
    input  wire logic                          start,
    output logic                               busy,
    output logic                               done,
    output logic                               mem_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0]      mem_read_addr,
    input  wire logic [DATA_WIDTH-1:0]         mem_rdata,
    conv_stream_feeder_if.master               out_if
);

    localparam int c_aw  = LOG2_OF_MEM_HEIGHT;
    localparam int c_xw  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
    localparam int c_yw  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int c_ciw = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
    localparam int c_cow = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;

    localparam logic [c_xw-1:0]  c_x_max  = c_xw'(FEATURE_MAP_WIDTH - 1);
    localparam logic [c_yw-1:0]  c_y_max  = c_yw'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [c_ciw-1:0] c_ci_max = c_ciw'(INPUT_NB_CHANNELS - 1);
    localparam logic [c_cow-1:0] c_co_max = c_cow'(OUTPUT_NB_CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Loop-nest position of the next word to be read; act_q selects the phase.
    logic             k_q,   k_d;
    logic             act_q, act_d;
    logic [c_xw-1:0]  x_q,   x_d;
    logic [c_yw-1:0]  y_q,   y_d;
    logic [c_cow-1:0] co_q,  co_d;
    logic [c_ciw-1:0] ci_q,  ci_d;

    logic             inflight_q;
    logic             infl_wt_q;
    logic             infl_last_q;

    logic [DATA_WIDTH-1:0] buf_data_q [0:1];
    logic                  buf_wt_q   [0:1];
    logic                  buf_last_q [0:1];
    logic                  head_q, head_d;
    logic [1:0]            cnt_q,  cnt_d;

    logic            w_valid;
    logic            w_pop;
    logic            w_tail;
    logic [2:0]      w_credit;
    logic            w_is_last;
    logic [c_aw-1:0] w_wt_addr;
    logic [c_aw-1:0] w_act_addr;

    // Arithmetic modulo 2**c_aw yields the same low bits as a full-width sum.
    assign w_wt_addr  = c_aw'(WEIGHT_BASE)
                      + ((c_aw'(ci_q) * c_aw'(OUTPUT_NB_CHANNELS) + c_aw'(co_q)) << 1)
                      + c_aw'(k_q);
    assign w_act_addr = c_aw'(ACT_BASE)
                      + ((((c_aw'(ci_q) * c_aw'(FEATURE_MAP_HEIGHT)) + c_aw'(y_q))
                          * c_aw'(FEATURE_MAP_WIDTH) + c_aw'(x_q)) << 1)
                      + c_aw'(k_q);

    assign w_is_last = act_q && k_q && (x_q == c_x_max) && (y_q == c_y_max)
                       && (co_q == c_co_max) && (ci_q == c_ci_max);

    assign w_valid  = (cnt_q != 2'd0);
    assign w_pop    = w_valid && out_if.out_ready;
    assign w_tail   = head_q ^ cnt_q[0];
    assign w_credit = {1'b0, cnt_q} + {2'b00, inflight_q};

    assign cnt_d  = cnt_q + {1'b0, inflight_q} - {1'b0, w_pop};
    assign head_d = w_pop ? ~head_q : head_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        act_d   = act_q;
        x_d     = x_q;
        y_d     = y_q;
        co_d    = co_q;
        ci_d    = ci_q;
        mem_re  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    k_d     = 1'b0;
                    act_d   = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    co_d    = '0;
                    ci_d    = '0;
                end
            end
            S_ISSUE: begin
                mem_re = (w_credit < 3'd2) || ((w_credit == 3'd2) && w_pop);
                if (mem_re) begin
                    if (w_is_last) begin
                        state_d = S_DRAIN;
                    end
                    if (!k_q) begin
                        k_d = 1'b1;
                    end else begin
                        k_d = 1'b0;
                        if (!act_q) begin
                            act_d = 1'b1;
                        end else if (x_q != c_x_max) begin
                            x_d = x_q + 1'b1;
                        end else begin
                            x_d = '0;
                            if (y_q != c_y_max) begin
                                y_d = y_q + 1'b1;
                            end else begin
                                y_d   = '0;
                                act_d = 1'b0;
                                if (co_q != c_co_max) begin
                                    co_d = co_q + 1'b1;
                                end else begin
                                    co_d = '0;
                                    ci_d = (ci_q == c_ci_max) ? '0 : ci_q + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if ((cnt_q == 2'd0) && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            k_q         <= 1'b0;
            act_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            co_q        <= '0;
            ci_q        <= '0;
            inflight_q  <= 1'b0;
            infl_wt_q   <= 1'b0;
            infl_last_q <= 1'b0;
            head_q      <= 1'b0;
            cnt_q       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_wt_q[i]   <= 1'b0;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            act_q       <= act_d;
            x_q         <= x_d;
            y_q         <= y_d;
            co_q        <= co_d;
            ci_q        <= ci_d;
            inflight_q  <= mem_re;
            infl_wt_q   <= ~act_q;
            infl_last_q <= w_is_last;
            head_q      <= head_d;
            cnt_q       <= cnt_d;
            if (inflight_q) begin
                buf_data_q[w_tail] <= mem_rdata;
                buf_wt_q[w_tail]   <= infl_wt_q;
                buf_last_q[w_tail] <= infl_last_q;
            end
        end
    end

    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign mem_read_addr = mem_re ? (act_q ? w_act_addr : w_wt_addr) : '0;

    assign out_if.out_valid     = w_valid;
    assign out_if.out_data      = w_valid ? buf_data_q[head_q] : '0;
    assign out_if.out_is_weight = w_valid && buf_wt_q[head_q];
    assign out_if.out_last      = w_valid && buf_last_q[head_q];

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_stream_feeder
// Brief    : Directed self-checking bench for conv_stream_feeder (2x2x2x2 map).
// Revision : 1.0
// ============================================================================
module tb_conv_stream_feeder;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int W  = 2;
    localparam int H  = 2;
    localparam int NI = 2;
    localparam int NO = 2;
    localparam int WB = 0;
    localparam int AB = 64;
    localparam int NW = NI * NO * (2 + 2 * W * H);

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_re;
    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_rdata;

    conv_stream_feeder_if #(.DATA_WIDTH(DW)) s_if ();

    conv_stream_feeder #(
        .LOG2_OF_MEM_HEIGHT (AW),
        .DATA_WIDTH         (DW),
        .FEATURE_MAP_WIDTH  (W),
        .FEATURE_MAP_HEIGHT (H),
        .INPUT_NB_CHANNELS  (NI),
        .OUTPUT_NB_CHANNELS (NO),
        .WEIGHT_BASE        (WB),
        .ACT_BASE           (AB)
    ) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_re        (mem_re),
        .mem_read_addr (mem_read_addr),
        .mem_rdata     (mem_rdata),
        .out_if        (s_if.master)
    );

    always #5 clk = ~clk;

    // Operand memory: each word holds its own address, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_re === 1'b1) mem_rdata <= DW'(mem_read_addr);
    end

    int checks = 0;
    int errors = 0;

    int exp_data [NW];
    int exp_wt   [NW];
    int exp_last [NW];
    int recv     [NW];

    int widx, done_cnt, done_n, last_n, nre, n_cur, m_buf, m_infl;
    bit prev_stall, last_pop;
    logic [DW-1:0] prev_data;
    logic prev_wt, prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        bit pop;
        int credit;
        pop    = (s_if.out_valid === 1'b1) && (s_if.out_ready === 1'b1);
        credit = m_buf + m_infl;
        chk("valid_vs_model", 32'(s_if.out_valid), 32'(m_buf > 0));
        if (mem_re === 1'b1) begin
            nre++;
            chk("issue_credit", 32'((credit < 2) || pop), 32'd1);
        end
        if (prev_stall) begin
            chk("hold_data", 32'(s_if.out_data), 32'(prev_data));
            chk("hold_wt",   32'(s_if.out_is_weight), 32'(prev_wt));
            chk("hold_last", 32'(s_if.out_last), 32'(prev_last));
        end
        if (pop) begin
            if (widx < NW) begin
                chk("word_data", 32'(s_if.out_data), 32'(exp_data[widx]));
                chk("word_wt",   32'(s_if.out_is_weight), 32'(exp_wt[widx]));
                chk("word_last", 32'(s_if.out_last), 32'(exp_last[widx]));
                recv[widx] = int'(s_if.out_data);
            end else begin
                chk("extra_word", 32'(widx), 32'(NW - 1));
            end
            widx++;
            last_n = n_cur;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_n = n_cur;
        end
        prev_stall = (s_if.out_valid === 1'b1) && !pop;
        prev_data  = s_if.out_data;
        prev_wt    = s_if.out_is_weight;
        prev_last  = s_if.out_last;
        m_buf      = m_buf + m_infl - (pop ? 1 : 0);
        m_infl     = (mem_re === 1'b1) ? 1 : 0;
        last_pop   = pop;
    endtask

    task automatic cycle(input bit rdy, input bit st, input bit st_on_done);
        @(posedge clk);
        #1;
        s_if.out_ready = rdy;
        start = st | (st_on_done & (done === 1'b1));
        #1;
        n_cur++;
        observe();
    endtask

    task automatic begin_pass();
        widx = 0; done_cnt = 0; done_n = -1; last_n = -1; nre = 0; n_cur = 0;
        prev_stall = 1'b0; m_buf = 0; m_infl = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
    endtask

    // mode 0: ready high; 1: random ready; 2: random + stray starts; 3: stall 8 cycles
    task automatic run_pass(input int mode);
        bit rdy, st;
        begin_pass();
        for (int n = 1; n <= 600; n++) begin
            case (mode)
                0:       rdy = 1'b1;
                3:       rdy = (n > 8);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            st = (mode == 2) && ((n == 4) || (n == 25));
            cycle(rdy, st, mode == 2);
            if (mode == 0) begin
                if (n == 1) begin
                    chk("lat_c1_mem_re", 32'(mem_re), 32'd1);
                    chk("lat_c1_busy",   32'(busy), 32'd1);
                    chk("lat_c1_addr",   32'(mem_read_addr), 32'd0);
                end
                if (n == 2) begin
                    chk("lat_c2_valid", 32'(s_if.out_valid), 32'd0);
                    chk("lat_c2_addr",  32'(mem_read_addr), 32'd1);
                end
                if (n == 3) begin
                    chk("lat_c3_valid", 32'(s_if.out_valid), 32'd1);
                    chk("lat_c3_addr",  32'(mem_read_addr), 32'd64);
                end
                if ((n >= 3) && (n <= NW + 2)) chk("no_bubble", 32'(last_pop), 32'd1);
            end
            if ((mode == 3) && (n == 8)) begin
                chk("stall_reads",  32'(nre), 32'd2);
                chk("stall_mem_re", 32'(mem_re), 32'd0);
                chk("stall_valid",  32'(s_if.out_valid), 32'd1);
                chk("stall_data",   32'(s_if.out_data), 32'd0);
                chk("stall_wt",     32'(s_if.out_is_weight), 32'd1);
            end
            if ((done_cnt > 0) && (n >= done_n + 4)) break;
        end
        chk("pass_words",      32'(widx), 32'(NW));
        chk("pass_reads",      32'(nre), 32'(NW));
        chk("done_pulses",     32'(done_cnt), 32'd1);
        chk("done_after_last", 32'(done_n > last_n), 32'd1);
        chk("idle_busy",       32'(busy), 32'd0);
    endtask

    initial begin
        int idx;
        int first10 [10];
        first10 = '{0, 1, 64, 65, 66, 67, 68, 69, 70, 71};

        idx = 0;
        for (int ci = 0; ci < NI; ci++) begin
            for (int co = 0; co < NO; co++) begin
                for (int k = 0; k < 2; k++) begin
                    exp_data[idx] = WB + (ci * NO + co) * 2 + k;
                    exp_wt[idx]   = 1;
                    exp_last[idx] = 0;
                    idx++;
                end
                for (int y = 0; y < H; y++) begin
                    for (int x = 0; x < W; x++) begin
                        for (int k = 0; k < 2; k++) begin
                            exp_data[idx] = AB + ((ci * H + y) * W + x) * 2 + k;
                            exp_wt[idx]   = 0;
                            exp_last[idx] = (idx == NW - 1) ? 1 : 0;
                            idx++;
                        end
                    end
                end
            end
        end

        rst_in = 1'b1;
        start  = 1'b0;
        s_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_addr",  32'(mem_read_addr), 32'd0);
        chk("rst_valid", 32'(s_if.out_valid), 32'd0);
        chk("rst_data",  32'(s_if.out_data), 32'd0);
        chk("rst_last",  32'(s_if.out_last), 32'd0);
        rst_in = 1'b0;

        // Full-rate pass, then hand-computed order and group boundaries.
        run_pass(0);
        for (int i = 0; i < 10; i++) chk("first10", 32'(recv[i]), 32'(first10[i]));
        chk("word11_wt_addr", 32'(recv[10]), 32'd2);
        chk("word21_wt_addr", 32'(recv[20]), 32'd4);
        for (int i = 0; i < 8; i++) chk("words23_30", 32'(recv[22 + i]), 32'(72 + i));
        chk("word40_data", 32'(recv[39]), 32'd79);

        run_pass(3);
        chk("resume_word2", 32'(recv[1]), 32'd1);

        run_pass(1);

        // Reset in the middle of a pass with a read outstanding.
        begin_pass();
        for (int n = 1; (n <= 200) && (widx < 15); n++) cycle(1'b1, 1'b0, 1'b0);
        chk("pre_reset_words",    32'(widx), 32'd15);
        chk("pre_reset_inflight", 32'(m_infl), 32'd1);
        @(posedge clk);
        #1;
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        chk("mid_rst_busy",   32'(busy), 32'd0);
        chk("mid_rst_valid",  32'(s_if.out_valid), 32'd0);
        chk("mid_rst_mem_re", 32'(mem_re), 32'd0);
        chk("mid_rst_done",   32'(done), 32'd0);
        m_buf = 0; m_infl = 0; prev_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            chk("stale_dropped", 32'(s_if.out_valid), 32'd0);
        end
        run_pass(1);
        chk("replay_first", 32'(recv[0]), 32'd0);

        // Stray starts while busy and during DONE.
        run_pass(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
